perceptron_train_ctrl: RTL and testbench

Upstream training controller for perceptron_dp. Accepts labelled training samples over a valid/ready handshake, drives X0_i/X1_i/enable into the datapath, and waits a fixed datapath latency to sample Y_o. On misclassification it applies a sign-weight learning rule and reloads b/W0/W1 through the datapath's serial weight-load port. It also reports per-epoch error counts and convergence.

---
 rtl/perceptron_pkg.sv | 47 ++++
 rtl/perceptron_weight_rule.sv | 30 +++
 rtl/perceptron_train_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_perceptron_train_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron training controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package perceptron_pkg;

    localparam int WIDTH_DEF = 8;

    // Weight-load select encoding on W1W0b_en_o
    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_W0   = 2'b10;
    localparam logic [1:0] SEL_W1   = 2'b11;

    // Sign-weight encoding: 1 means +1, 0 means -1
    localparam logic W_POS = 1'b1;
    localparam logic W_NEG = 1'b0;

    // Bit positions within the packed {W1,W0,b} weight vector
    localparam int IDX_B  = 0;
    localparam int IDX_W0 = 1;
    localparam int IDX_W1 = 2;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_EVAL,
        ST_WAIT,
        ST_CHECK,
        ST_UPD_B,
        ST_UPD_W0,
        ST_UPD_W1
    } state_t;

    // Positive feature pulls the weight toward the target sign, negative away;
    // a zero feature carries no information so the weight is kept.
    function automatic logic sign_rule(input logic old_w, input logic pos,
                                       input logic neg, input logic target);
        logic w;
        w = old_w;
        if (pos)
            w = target ? W_POS : W_NEG;
        else if (neg)
            w = target ? W_NEG : W_POS;
        return w;
    endfunction

endpackage

// File: rtl/perceptron_weight_rule.sv
// Sign-weight learning rule: new {W1,W0,b} from features, target and old weights.
// Latency: combinational.
// Backpressure: none.
module perceptron_weight_rule
    import perceptron_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] x1,
    input  logic             target,
    input  logic [2:0]       w_old,
    output logic [2:0]       w_new
);

    logic x0_neg, x0_pos, x1_neg, x1_pos;

    always_comb begin
        x0_neg = x0[WIDTH-1];
        x0_pos = !x0[WIDTH-1] && (|x0);
        x1_neg = x1[WIDTH-1];
        x1_pos = !x1[WIDTH-1] && (|x1);

        w_new         = w_old;
        w_new[IDX_B]  = target ? W_POS : W_NEG;
        w_new[IDX_W0] = sign_rule(w_old[IDX_W0], x0_pos, x0_neg, target);
        w_new[IDX_W1] = sign_rule(w_old[IDX_W1], x1_pos, x1_neg, target);
    end

endmodule

// File: rtl/perceptron_train_ctrl.sv
// Training controller for perceptron_dp: evaluates samples, reloads weights on error, tracks epochs.
// Latency: 2+DP_LATENCY cycles per correct sample, 5+DP_LATENCY on error.
// Backpressure: s_ready only high in IDLE; one sample in flight at a time.
module perceptron_train_ctrl
    import perceptron_pkg::*;
#(
    parameter int         WIDTH      = WIDTH_DEF,
    parameter int         DP_LATENCY = 2,
    parameter int         ERR_W      = 16,
    parameter logic [2:0] INIT_W     = 3'b111
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_x0,
    input  logic [WIDTH-1:0] s_x1,
    input  logic             s_target,
    input  logic             s_last,
    output logic             enable,
    output logic [1:0]       W1W0b_en_o,
    output logic             b_o,
    output logic             W0_o,
    output logic             W1_o,
    output logic [WIDTH-1:0] X0_o,
    output logic [WIDTH-1:0] X1_o,
    input  logic             Y_i,
    output logic [2:0]       weights_o,
    output logic             epoch_done,
    output logic [ERR_W-1:0] epoch_errs,
    output logic             converged
);

    localparam logic [3:0] WAIT_INIT = 4'(DP_LATENCY - 1);

    state_t           state;
    logic [1:0]       init_cnt;
    logic [3:0]       wait_cnt;
    logic [ERR_W-1:0] err_cnt;
    logic             tgt_q;
    logic             last_q;
    logic [2:0]       w_new;

    perceptron_weight_rule #(
        .WIDTH (WIDTH)
    ) u_rule (
        .x0     (X0_o),
        .x1     (X1_o),
        .target (tgt_q),
        .w_old  (weights_o),
        .w_new  (w_new)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_INIT;
            init_cnt   <= 2'd0;
            wait_cnt   <= 4'd0;
            err_cnt    <= '0;
            tgt_q      <= 1'b0;
            last_q     <= 1'b0;
            s_ready    <= 1'b0;
            enable     <= 1'b0;
            W1W0b_en_o <= SEL_NONE;
            b_o        <= 1'b0;
            W0_o       <= 1'b0;
            W1_o       <= 1'b0;
            X0_o       <= '0;
            X1_o       <= '0;
            weights_o  <= INIT_W;
            epoch_done <= 1'b0;
            epoch_errs <= '0;
            converged  <= 1'b0;
        end else begin
            // Strobes and load lines are single-cycle unless a state re-asserts them
            enable     <= 1'b0;
            W1W0b_en_o <= SEL_NONE;
            b_o        <= 1'b0;
            W0_o       <= 1'b0;
            W1_o       <= 1'b0;
            epoch_done <= 1'b0;

            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 2'd1;
                    case (init_cnt)
                        2'd0: begin
                            W1W0b_en_o <= SEL_B;
                            b_o        <= INIT_W[IDX_B];
                        end
                        2'd1: begin
                            W1W0b_en_o <= SEL_W0;
                            W0_o       <= INIT_W[IDX_W0];
                        end
                        2'd2: begin
                            W1W0b_en_o <= SEL_W1;
                            W1_o       <= INIT_W[IDX_W1];
                        end
                        default: begin
                            init_cnt <= 2'd0;
                            s_ready  <= 1'b1;
                            state    <= ST_IDLE;
                        end
                    endcase
                end

                ST_IDLE: begin
                    if (s_valid) begin
                        X0_o    <= s_x0;
                        X1_o    <= s_x1;
                        tgt_q   <= s_target;
                        last_q  <= s_last;
                        s_ready <= 1'b0;
                        enable  <= 1'b1;
                        state   <= ST_EVAL;
                    end
                end

                ST_EVAL: begin
                    wait_cnt <= WAIT_INIT;
                    state    <= (WAIT_INIT == 4'd0) ? ST_CHECK : ST_WAIT;
                end

                // Y_i is sampled exactly DP_LATENCY cycles after the enable pulse
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1)
                        state <= ST_CHECK;
                end

                ST_CHECK: begin
                    if (Y_i != tgt_q) begin
                        if (err_cnt != '1)
                            err_cnt <= err_cnt + 1'b1;
                        weights_o  <= w_new;
                        W1W0b_en_o <= SEL_B;
                        b_o        <= w_new[IDX_B];
                        state      <= ST_UPD_B;
                    end else begin
                        if (last_q) begin
                            epoch_done <= 1'b1;
                            epoch_errs <= err_cnt;
                            converged  <= (err_cnt == '0);
                            err_cnt    <= '0;
                        end
                        s_ready <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end

                ST_UPD_B: begin
                    W1W0b_en_o <= SEL_W0;
                    W0_o       <= weights_o[IDX_W0];
                    state      <= ST_UPD_W0;
                end

                ST_UPD_W0: begin
                    W1W0b_en_o <= SEL_W1;
                    W1_o       <= weights_o[IDX_W1];
                    state      <= ST_UPD_W1;
                end

                // err_cnt already includes this sample's error here
                ST_UPD_W1: begin
                    if (last_q) begin
                        epoch_done <= 1'b1;
                        epoch_errs <= err_cnt;
                        converged  <= (err_cnt == '0);
                        err_cnt    <= '0;
                    end
                    s_ready <= 1'b1;
                    state   <= ST_IDLE;
                end

                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Directed bench for perceptron_train_ctrl: init load, learning rule, epochs, reset mid-sample.
module tb_perceptron_train_ctrl;

    localparam int WIDTH = 8;
    localparam int L     = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [WIDTH-1:0] s_x0 = '0;
    logic [WIDTH-1:0] s_x1 = '0;
    logic             s_target = 1'b0;
    logic             s_last = 1'b0;
    logic             enable;
    logic [1:0]       W1W0b_en_o;
    logic             b_o, W0_o, W1_o;
    logic [WIDTH-1:0] X0_o, X1_o;
    logic             Y_i = 1'b0;
    logic [2:0]       weights_o;
    logic             epoch_done;
    logic [15:0]      epoch_errs;
    logic             converged;

    perceptron_train_ctrl #(
        .WIDTH      (WIDTH),
        .DP_LATENCY (L),
        .ERR_W      (16),
        .INIT_W     (3'b111)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_x0       (s_x0),
        .s_x1       (s_x1),
        .s_target   (s_target),
        .s_last     (s_last),
        .enable     (enable),
        .W1W0b_en_o (W1W0b_en_o),
        .b_o        (b_o),
        .W0_o       (W0_o),
        .W1_o       (W1_o),
        .X0_o       (X0_o),
        .X1_o       (X1_o),
        .Y_i        (Y_i),
        .weights_o  (weights_o),
        .epoch_done (epoch_done),
        .epoch_errs (epoch_errs),
        .converged  (converged)
    );

    always #5 clk = ~clk;

    int npass = 0;
    int nfail = 0;
    int ntot  = 0;

    // per-sample observations
    int         cyc, n_en, n_load, bad_lines, overlap, x_bad, done_cnt;
    logic [5:0] sels;
    logic [2:0] vals;
    logic [15:0] done_errs;
    logic       done_conv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge one clock after reset was sampled high.
    task automatic init_seq(input string tag);
        chk({tag, "_rst_ready"}, s_ready, 0);
        chk({tag, "_rst_enable"}, enable, 0);
        chk({tag, "_rst_sel"}, W1W0b_en_o, 0);
        chk({tag, "_rst_lines"}, {b_o, W0_o, W1_o}, 0);
        chk({tag, "_rst_x"}, {X0_o, X1_o}, 0);
        chk({tag, "_rst_weights"}, weights_o, 3'b111);
        chk({tag, "_rst_done"}, epoch_done, 0);
        chk({tag, "_rst_errs"}, epoch_errs, 0);
        chk({tag, "_rst_conv"}, converged, 0);
        reset = 1'b0;
        @(negedge clk);
        chk({tag, "_init1"}, {s_ready, W1W0b_en_o, b_o, W0_o, W1_o}, 6'b0_01_100);
        @(negedge clk);
        chk({tag, "_init2"}, {s_ready, W1W0b_en_o, b_o, W0_o, W1_o}, 6'b0_10_010);
        @(negedge clk);
        chk({tag, "_init3"}, {s_ready, W1W0b_en_o, b_o, W0_o, W1_o}, 6'b0_11_001);
        @(negedge clk);
        chk({tag, "_init_ready"}, {s_ready, W1W0b_en_o, epoch_done}, 4'b1_00_0);
    endtask

    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        while (!s_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_ready_wait"}, s_ready, 1);
    endtask

    task automatic sample(input string tag, input logic [7:0] x0, input logic [7:0] x1,
                          input logic t, input logic lst, input logic y,
                          input logic [2:0] exp_w, input logic exp_done,
                          input logic [15:0] exp_errs, input logic exp_conv);
        logic err;
        logic v;
        err = (y != t);
        wait_ready(tag);
        s_valid = 1'b1; s_x0 = x0; s_x1 = x1; s_target = t; s_last = lst; Y_i = y;
        @(posedge clk);
        cyc = 0; n_en = 0; n_load = 0; bad_lines = 0; overlap = 0; x_bad = 0; done_cnt = 0;
        sels = '0; vals = '0; done_errs = '0; done_conv = 1'b0;
        @(negedge clk);
        s_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc++;
            if (enable) n_en++;
            if (enable && W1W0b_en_o != 2'b00) overlap++;
            if (epoch_done) begin
                done_cnt++;
                done_errs = epoch_errs;
                done_conv = converged;
            end
            if (W1W0b_en_o != 2'b00) begin
                n_load++;
                v = (W1W0b_en_o == 2'b01) ? b_o : (W1W0b_en_o == 2'b10) ? W0_o : W1_o;
                sels = {sels[3:0], W1W0b_en_o};
                vals = {vals[1:0], v};
            end
            if ((W1W0b_en_o != 2'b01 && b_o) || (W1W0b_en_o != 2'b10 && W0_o) ||
                (W1W0b_en_o != 2'b11 && W1_o))
                bad_lines++;
            if (s_ready) break;
            if (X0_o !== x0 || X1_o !== x1) x_bad++;
            @(negedge clk);
        end
        chk({tag, "_cycles"}, cyc, err ? L + 5 : L + 2);
        chk({tag, "_enables"}, n_en, 1);
        chk({tag, "_loads"}, n_load, err ? 3 : 0);
        chk({tag, "_overlap"}, overlap, 0);
        chk({tag, "_x_stable"}, x_bad, 0);
        chk({tag, "_idle_lines"}, bad_lines, 0);
        chk({tag, "_weights"}, weights_o, exp_w);
        if (err) begin
            chk({tag, "_load_order"}, sels, 6'b01_10_11);
            chk({tag, "_load_vals"}, vals, {exp_w[0], exp_w[1], exp_w[2]});
        end
        chk({tag, "_done"}, done_cnt, exp_done);
        if (exp_done) begin
            chk({tag, "_epoch_errs"}, done_errs, exp_errs);
            chk({tag, "_converged"}, done_conv, exp_conv);
        end
    endtask

    initial begin
        @(negedge clk);
        init_seq("boot");

        // epoch 1: directed learning-rule cases, last on the 4th
        sample("correct",  8'd20, 8'hFB, 1'b1, 1'b0, 1'b1, 3'b111, 1'b0, 16'd0, 1'b0);
        sample("err_t0",   8'd20, 8'hFB, 1'b0, 1'b0, 1'b1, 3'b100, 1'b0, 16'd0, 1'b0);
        sample("to_zero",  8'd3,  8'd4,  1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 16'd0, 1'b0);
        sample("x0_zero",  8'd0,  8'd7,  1'b1, 1'b1, 1'b0, 3'b101, 1'b1, 16'd3, 1'b0);

        // epoch 2: one error
        sample("e2_s1",    8'd5,  8'd5,  1'b1, 1'b0, 1'b1, 3'b101, 1'b0, 16'd0, 1'b0);
        sample("e2_s2",    8'hFD, 8'd2,  1'b0, 1'b0, 1'b0, 3'b101, 1'b0, 16'd0, 1'b0);
        sample("e2_neg",   8'hF6, 8'hF6, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 16'd0, 1'b0);
        sample("e2_s4",    8'd1,  8'd1,  1'b0, 1'b1, 1'b0, 3'b001, 1'b1, 16'd1, 1'b0);

        // epoch 3: no errors
        sample("e3_s1",    8'd2,  8'hFE, 1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 16'd0, 1'b0);
        sample("e3_s2",    8'hFF, 8'd0,  1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 16'd0, 1'b0);
        sample("e3_s3",    8'd0,  8'd0,  1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 16'd0, 1'b0);
        sample("e3_s4",    8'd100, 8'h9C, 1'b0, 1'b1, 1'b0, 3'b001, 1'b1, 16'd0, 1'b1);

        // error that must be forgotten by the reset below
        sample("pre_rst",  8'd7,  8'd7,  1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 16'd0, 1'b0);

        // reset while the next sample sits in WAIT
        wait_ready("rst");
        s_valid = 1'b1; s_x0 = 8'd9; s_x1 = 8'd9; s_target = 1'b1; s_last = 1'b1; Y_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        chk("rst_eval_enable", enable, 1);
        @(negedge clk);
        chk("rst_wait_enable", {enable, s_ready}, 2'b00);
        reset = 1'b1;
        @(negedge clk);
        init_seq("rst");

        // error count cleared by reset: a single correct last sample converges
        sample("post_rst", 8'd1,  8'd1,  1'b1, 1'b1, 1'b1, 3'b111, 1'b1, 16'd0, 1'b1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
